// File: rtl/sequential_divider.sv
// sequential_divider: constant-latency restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor
module sequential_divider #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 quotientDone,
  output logic                 busy,
  output logic                 overflow,
  output logic                 divByZero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nextState;
  logic [WIDTH-1:0] divReg, lowReg, remReg, shiftReg, nextRem;
  logic [WIDTH:0] trial;
  logic [CW-1:0] count;
  logic ovfReg, dbzReg, qbit, last, accept;
  always_comb begin
    trial = {remReg, shiftReg[WIDTH-1]};
    qbit = trial >= {1'b0, divReg};
    nextRem = qbit ? WIDTH'(trial - {1'b0, divReg}) : trial[WIDTH-1:0];
    last = count == CW'(WIDTH - 1);
    accept = state == IDLE && start;
    nextState = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) state <= !rst ? IDLE : nextState;
  // the dividend's low half doubles as the quotient shift register: quotient bits fill in from the LSB
  always_ff @(posedge clk) begin
    if (!rst) begin
      quotient <= '0;
      remainder <= '0;
      overflow <= 1'b0;
      divByZero <= 1'b0;
      count <= '0;
    end else if (accept) begin
      divReg <= divisor;
      lowReg <= dividend[WIDTH-1:0];
      remReg <= dividend[2*WIDTH-1:WIDTH];
      shiftReg <= dividend[WIDTH-1:0];
      count <= '0;
      dbzReg <= divisor == '0;
      ovfReg <= divisor != '0 && dividend[2*WIDTH-1:WIDTH] >= divisor;
    end else if (state == RUN) begin
      remReg <= nextRem;
      shiftReg <= {shiftReg[WIDTH-2:0], qbit};
      count <= count + 1'b1;
      if (last) begin
        quotient <= (dbzReg || ovfReg) ? '1 : {shiftReg[WIDTH-2:0], qbit};
        remainder <= dbzReg ? lowReg : ovfReg ? '0 : nextRem;
        overflow <= ovfReg;
        divByZero <= dbzReg;
      end
    end
  end
  assign quotientDone = state == DONE;
  assign busy = state != IDLE;
endmodule
